// File: rtl/mux2_stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux2_stream_arb_pkg
// Brief    : Owner-state encoding and source ids shared by the stream mux/demux.
// Revision : 1.0 - initial release
// ============================================================================
package mux2_stream_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic owner_e owner_of(input logic sel);
        return (sel == SRC_B) ? OWN_B : OWN_A;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_stream_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant with bounded burst hold on ties.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mux2_stream_arb_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = 2
) (
    input  logic             i_a_valid,
    input  logic             i_b_valid,
    input  logic             i_load,
    input  logic             i_last_sel,
    input  owner_e           i_state,
    input  logic [CNT_W-1:0] i_burst_cnt,
    output logic             o_grant_valid,
    output logic             o_grant_sel
);

    localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(BURST - 1);

    logic w_hold;

    // The current owner keeps a tie only while its burst budget is not spent.
    assign w_hold = (i_state == OWN_A || i_state == OWN_B) && (i_burst_cnt < c_burst_max);

    always_comb begin
        o_grant_valid = i_load && (i_a_valid || i_b_valid);
        o_grant_sel   = SRC_A;
        if (i_a_valid && i_b_valid) begin
            if (w_hold) begin
                o_grant_sel = (i_state == OWN_B) ? SRC_B : SRC_A;
            end else begin
                o_grant_sel = ~i_last_sel;
            end
        end else if (i_b_valid) begin
            o_grant_sel = SRC_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux2_stream_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux2_stream_arb
// Brief    : Registered 2:1 stream mux with round-robin/burst arbitration and
//            a source tag on every output beat.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_stream_arb
    import mux2_stream_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    localparam int               c_cnt_w     = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(BURST - 1);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_sel;
    logic               r_last_sel;
    owner_e             r_state;
    owner_e             w_state_nxt;
    logic [c_cnt_w-1:0] r_burst_cnt;
    logic [c_cnt_w-1:0] w_burst_cnt_nxt;
    logic               w_load;
    logic               w_grant_valid;
    logic               w_grant_sel;

    assign w_load = !r_out_valid || out_ready;

    rr_arb2 #(
        .BURST (BURST),
        .CNT_W (c_cnt_w)
    ) u_arb (
        .i_a_valid     (a_valid),
        .i_b_valid     (b_valid),
        .i_load        (w_load),
        .i_last_sel    (r_last_sel),
        .i_state       (r_state),
        .i_burst_cnt   (r_burst_cnt),
        .o_grant_valid (w_grant_valid),
        .o_grant_sel   (w_grant_sel)
    );

    assign a_ready   = w_grant_valid && (w_grant_sel == SRC_A);
    assign b_ready   = w_grant_valid && (w_grant_sel == SRC_B);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

    // last_sel resets to B so that A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= SRC_A;
            r_last_sel  <= SRC_B;
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= (w_grant_sel == SRC_B) ? b_data : a_data;
                r_out_sel   <= w_grant_sel;
                r_last_sel  <= w_grant_sel;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        if (w_load) begin
            if (w_grant_valid) begin
                if (r_state == owner_of(w_grant_sel)) begin
                    if (r_burst_cnt != c_burst_max) begin
                        w_burst_cnt_nxt = r_burst_cnt + c_cnt_w'(1);
                    end
                end else begin
                    w_state_nxt     = owner_of(w_grant_sel);
                    w_burst_cnt_nxt = '0;
                end
            end else begin
                w_state_nxt     = IDLE;
                w_burst_cnt_nxt = '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux2_stream_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_stream_arb
// Brief    : Self-checking bench for mux2_stream_arb (BURST=4 and BURST=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_stream_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_valid[2], b_valid[2], a_ready[2], b_ready[2];
    logic       out_valid[2], out_sel[2], out_ready[2];
    logic [7:0] a_data[2], b_data[2], out_data[2];

    int checks = 0;
    int errors = 0;
    int c_burst[2] = '{4, 1};

    // Source beat queues, presentation flags and log of accepted output beats
    logic [7:0] qa[2][$];
    logic [7:0] qb[2][$];
    logic       a_off[2], b_off[2];
    logic [7:0] log_dat[2][$];
    logic       log_sel[2][$];
    int         rdy_mode;
    bit         rand_gate;

    // Reference model: output register plus the current run of same-source beats
    logic       m_ov[2], m_os[2], m_last[2], m_rsrc[2];
    logic [7:0] m_od[2];
    int         m_rlen[2];

    logic [7:0] gap_dat[2][8] = '{'{8'h41, 8'h42, 8'h51, 8'h52, 8'h53, 8'h54, 8'h43, 8'h55},
                                  '{8'h41, 8'h42, 8'h51, 8'h43, 8'h52, 8'h53, 8'h54, 8'h55}};
    logic       gap_sel[2][8] = '{'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
                                  '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}};

    mux2_stream_arb #(.WIDTH(8), .BURST(4)) u_dut_b4 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[0]), .a_data(a_data[0]), .a_ready(a_ready[0]),
        .b_valid(b_valid[0]), .b_data(b_data[0]), .b_ready(b_ready[0]),
        .out_valid(out_valid[0]), .out_data(out_data[0]), .out_sel(out_sel[0]),
        .out_ready(out_ready[0])
    );

    mux2_stream_arb #(.WIDTH(8), .BURST(1)) u_dut_b1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[1]), .a_data(a_data[1]), .a_ready(a_ready[1]),
        .b_valid(b_valid[1]), .b_data(b_data[1]), .b_ready(b_ready[1]),
        .out_valid(out_valid[1]), .out_data(out_data[1]), .out_sel(out_sel[1]),
        .out_ready(out_ready[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[burst=%0d] t=%0t: got %0h, expected %0h", name, c_burst[k], $time, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input int k, input int i, input logic sel, input logic [7:0] dat);
        if (i < log_sel[k].size()) begin
            chk({name, "_sel"}, k, 32'(log_sel[k][i]), 32'(sel));
            chk({name, "_data"}, k, 32'(log_dat[k][i]), 32'(dat));
        end else begin
            chk({name, "_beats"}, k, log_sel[k].size(), i + 1);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 1'b0; m_od[k] = 8'h00; m_os[k] = 1'b0;
            m_last[k] = 1'b1; m_rsrc[k] = 1'b0; m_rlen[k] = 0;
            qa[k].delete(); qb[k].delete();
            a_off[k] = 1'b0; b_off[k] = 1'b0;
            log_dat[k].delete(); log_sel[k].delete();
        end
    endtask

    // One clock: drive at negedge, compare DUT to model, advance the model.
    task automatic step();
        logic load, win, gnt;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!a_off[k] && qa[k].size() > 0) a_off[k] = rand_gate ? (($urandom % 4) != 0) : 1'b1;
            if (!b_off[k] && qb[k].size() > 0) b_off[k] = rand_gate ? (($urandom % 4) != 0) : 1'b1;
            a_valid[k]   = a_off[k];
            b_valid[k]   = b_off[k];
            a_data[k]    = a_off[k] ? qa[k][0] : 8'($urandom);
            b_data[k]    = b_off[k] ? qb[k][0] : 8'($urandom);
            out_ready[k] = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 0) ? 1'b0 : (($urandom % 4) != 0);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            load = !m_ov[k] || out_ready[k];
            if (a_valid[k] && b_valid[k])
                win = (m_rlen[k] > 0 && m_rlen[k] < c_burst[k]) ? m_rsrc[k] : !m_last[k];
            else
                win = b_valid[k];
            gnt = load && (a_valid[k] || b_valid[k]);

            chk("a_ready", k, 32'(a_ready[k]), 32'(gnt && !win));
            chk("b_ready", k, 32'(b_ready[k]), 32'(gnt && win));
            chk("out_valid", k, 32'(out_valid[k]), 32'(m_ov[k]));
            chk("out_data", k, 32'(out_data[k]), 32'(m_od[k]));
            chk("out_sel", k, 32'(out_sel[k]), 32'(m_os[k]));

            if (out_valid[k] && out_ready[k]) begin
                log_dat[k].push_back(out_data[k]);
                log_sel[k].push_back(out_sel[k]);
            end

            if (gnt) begin
                if (win) begin m_od[k] = qb[k].pop_front(); b_off[k] = 1'b0; end
                else     begin m_od[k] = qa[k].pop_front(); a_off[k] = 1'b0; end
                m_os[k]   = win;
                m_ov[k]   = 1'b1;
                m_last[k] = win;
                if (m_rlen[k] > 0 && m_rsrc[k] == win) m_rlen[k]++;
                else begin m_rsrc[k] = win; m_rlen[k] = 1; end
            end else if (load) begin
                m_ov[k]   = 1'b0;
                m_rlen[k] = 0;
            end
        end
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin a_valid[k] = 1'b0; b_valid[k] = 1'b0; end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, 32'(out_valid[k]), 0);
            chk("rst_out_data", k, 32'(out_data[k]), 0);
            chk("rst_out_sel", k, 32'(out_sel[k]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        rdy_mode = 1;
        rand_gate = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = 1'b0; b_valid[k] = 1'b0; out_ready[k] = 1'b1;
            a_data[k] = 8'h00; b_data[k] = 8'h00;
        end
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("init_out_valid", k, 32'(out_valid[k]), 0);
            chk("init_out_data", k, 32'(out_data[k]), 0);
        end
        rst = 1'b0;

        // Lone source A streams back to back
        for (int k = 0; k < 2; k++) begin
            qa[k].push_back(8'h11); qa[k].push_back(8'h12); qa[k].push_back(8'h13);
        end
        repeat (6) step();
        for (int k = 0; k < 2; k++) begin
            chk("single_beats", k, log_sel[k].size(), 3);
            for (int i = 0; i < 3; i++) chk_beat("single", k, i, 1'b0, 8'(8'h11 + i));
        end

        // Continuous tie: N beats A, N beats B, ...
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) begin
                qa[k].push_back(8'(8'hA0 + i));
                qb[k].push_back(8'(8'hB0 + i));
            end
        repeat (18) step();
        for (int k = 0; k < 2; k++) begin
            chk("tie_beats", k, log_sel[k].size(), 16);
            for (int i = 0; i < 16; i++) begin
                int g, idx;
                logic s;
                g   = i / c_burst[k];
                s   = logic'(g % 2);
                idx = (g / 2) * c_burst[k] + i % c_burst[k];
                chk_beat("tie", k, i, s, s ? 8'(8'hB0 + idx) : 8'(8'hA0 + idx));
            end
        end

        // Backpressure: held output and zero readies, then no-bubble resume
        do_reset();
        rdy_mode = 0;
        for (int k = 0; k < 2; k++) begin
            qa[k].push_back(8'h21); qa[k].push_back(8'h22); qb[k].push_back(8'h31);
        end
        repeat (4) step();
        for (int k = 0; k < 2; k++) begin
            chk("bp_hold_data", k, 32'(out_data[k]), 32'h21);
            chk("bp_hold_sel", k, 32'(out_sel[k]), 0);
            chk("bp_a_ready", k, 32'(a_ready[k]), 0);
            chk("bp_b_ready", k, 32'(b_ready[k]), 0);
        end
        rdy_mode = 1;
        repeat (5) step();
        for (int k = 0; k < 2; k++) begin
            chk_beat("bp", k, 0, 1'b0, 8'h21);
            chk_beat("bp", k, 1, logic'(k), (k == 1) ? 8'h31 : 8'h22);
        end

        // Gap then tie: B wins after A, burst count restarts
        do_reset();
        for (int k = 0; k < 2; k++) begin qa[k].push_back(8'h41); qa[k].push_back(8'h42); end
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            qa[k].push_back(8'h43);
            for (int i = 0; i < 5; i++) qb[k].push_back(8'(8'h51 + i));
        end
        step();
        for (int k = 0; k < 2; k++) chk("gap_out_valid", k, 32'(out_valid[k]), 0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("gap_first_sel", k, 32'(out_sel[k]), 1);
            chk("gap_first_data", k, 32'(out_data[k]), 32'h51);
        end
        repeat (10) step();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) chk_beat("gap", k, i, gap_sel[k][i], gap_dat[k][i]);

        // Reset while a beat is held: discarded, then A preferred again
        rdy_mode = 0;
        for (int k = 0; k < 2; k++) qa[k].push_back(8'h61);
        repeat (2) step();
        for (int k = 0; k < 2; k++) chk("pre_rst_out_valid", k, 32'(out_valid[k]), 1);
        do_reset();
        rdy_mode = 1;
        for (int k = 0; k < 2; k++) begin qa[k].push_back(8'h71); qb[k].push_back(8'h81); end
        repeat (3) step();
        for (int k = 0; k < 2; k++) chk_beat("post_rst", k, 0, 1'b0, 8'h71);

        // Randomised traffic and backpressure against the model
        rdy_mode = 2;
        rand_gate = 1'b1;
        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                if (qa[k].size() < 3 && ($urandom % 2) == 1) qa[k].push_back(8'($urandom));
                if (qb[k].size() < 3 && ($urandom % 2) == 1) qb[k].push_back(8'($urandom));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
